// File: rtl/accum_pkg.sv
// Shared types and constants for the burst accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Per-beat operation select carried on in_sub.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/accum_alu.sv
// Unsigned add/subtract with carry/borrow detect and optional clamping.
// Latency: combinational.
// Backpressure: none; pure function of a, b and sub.
module accum_alu
  import accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SAT   = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH:0] ext;

  // One extra bit captures carry on add and borrow (wraparound) on subtract.
  always_comb begin
    if (sub == OP_SUB) begin
      ext = {1'b0, a} - {1'b0, b};
    end else begin
      ext = {1'b0, a} + {1'b0, b};
    end
    ovf    = ext[WIDTH];
    result = ext[WIDTH-1:0];
    if ((SAT != 0) && ovf) begin
      result = (sub == OP_SUB) ? '0 : '1;
    end
  end

endmodule

// File: rtl/accum_seq.sv
// Burst accumulator: sums len operands from a valid/ready stream, presents result.
// Latency: in_ready one cycle after start; out_valid one cycle after last beat.
// Backpressure: in_ready only in ACC; result held in DONE until out_ready.
module accum_seq
  import accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [WIDTH-1:0]   acc_d;
  logic               alu_ovf;
  logic               ovf_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               last_beat;

  accum_alu #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_alu (
    .a      (acc_q),
    .b      (in_data),
    .sub    (in_sub),
    .result (acc_d),
    .ovf    (alu_ovf)
  );

  // Next-state values for an accepted beat; len_q is never 0 while in ACC,
  // so len_q-1 cannot underflow and the counter stops short of wrapping.
  always_comb begin
    ovf_d     = ovf_q | alu_ovf;
    cnt_d     = cnt_q + CNT_W'(1);
    last_beat = (cnt_q == (len_q - CNT_W'(1)));
  end

  // Control FSM with datapath registers; handshake outputs are registered
  // alongside the state so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            len_q  <= len;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= ACC;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (last_beat) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_accum_seq.sv
module tb_accum_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_sub;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_ovf0, busy0;
  logic [15:0] out_sum0;
  logic        in_ready1, out_valid1, out_ovf1, busy1;
  logic [15:0] out_sum1;

  int n_vec;
  int n_err;

  accum_seq #(.WIDTH(16), .CNT_W(8), .SAT(0)) u_wrap (
    .clk(clk), .rstn(rstn), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_sub(in_sub),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
    .out_ovf(out_ovf0), .busy(busy0)
  );

  accum_seq #(.WIDTH(16), .CNT_W(8), .SAT(1)) u_sat (
    .clk(clk), .rstn(rstn), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_sub(in_sub),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
    .out_ovf(out_ovf1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    step();
    in_valid = 1'b0;
  endtask

  task automatic kick(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Status vector {in_ready, out_valid, out_ovf, busy, out_sum}.
  function automatic logic [31:0] st0();
    return {12'd0, in_ready0, out_valid0, out_ovf0, busy0, out_sum0};
  endfunction
  function automatic logic [31:0] st1();
    return {12'd0, in_ready1, out_valid1, out_ovf1, busy1, out_sum1};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_sub = 1'b0; out_ready = 1'b0;
    step();
    step();
    rstn = 1'b1;

    // Idle after reset: everything quiet for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_wrap", st0(), 32'h0);
    end
    chk("idle_sat", st1(), 32'h0);

    // len=3, 1+2+3 back-to-back.
    kick(8'd3);
    chk("acc_in_ready", {31'd0, in_ready0}, 32'd1);
    in_valid = 1'b1; in_sub = 1'b0;
    in_data = 16'h0001; step();
    in_data = 16'h0002; step();
    chk("no_early_valid", {31'd0, out_valid0}, 32'd0);
    in_data = 16'h0003; step();
    in_valid = 1'b0;
    chk("sum3_valid", {31'd0, out_valid0}, 32'd1);
    chk("sum3_sum", {16'd0, out_sum0}, 32'h0006);
    chk("sum3_ovf", {31'd0, out_ovf0}, 32'd0);
    chk("sum3_in_ready", {31'd0, in_ready0}, 32'd0);
    handshake();
    chk("sum3_back_idle", {31'd0, busy0}, 32'd0);

    // Add overflow: 0xFFFF + 0x0002.
    kick(8'd2);
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b0);
    chk("addovf_wrap_sum", {16'd0, out_sum0}, 32'h0001);
    chk("addovf_wrap_ovf", {31'd0, out_ovf0}, 32'd1);
    chk("addovf_sat_sum", {16'd0, out_sum1}, 32'hFFFF);
    chk("addovf_sat_ovf", {31'd0, out_ovf1}, 32'd1);
    handshake();

    // Subtract borrow: 0x0005 - 0x0007.
    kick(8'd2);
    beat(16'h0005, 1'b0);
    beat(16'h0007, 1'b1);
    chk("sub_wrap_sum", {16'd0, out_sum0}, 32'hFFFE);
    chk("sub_wrap_ovf", {31'd0, out_ovf0}, 32'd1);
    chk("sub_sat_sum", {16'd0, out_sum1}, 32'h0000);
    chk("sub_sat_ovf", {31'd0, out_ovf1}, 32'd1);
    handshake();

    // len=0: result next cycle, then held under backpressure with start pulsing.
    kick(8'd0);
    chk("len0_state", st0(), {12'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      len   = 8'd3;
      step();
      chk("len0_hold", st0(), {12'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000});
    end
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    chk("len0_hs_idle", st0(), 32'h0);
    step();
    chk("len0_start_ignored", {31'd0, busy0}, 32'd0);

    // Mid-burst reset after 2 accepted beats.
    kick(8'd4);
    beat(16'h0010, 1'b0);
    beat(16'h0020, 1'b0);
    chk("pre_rst_sum", {16'd0, out_sum0}, 32'h0030);
    rstn = 1'b0;
    step();
    chk("rst_wrap", st0(), 32'h0);
    chk("rst_sat", st1(), 32'h0);
    rstn = 1'b1;
    step();
    kick(8'd1);
    beat(16'h0009, 1'b0);
    chk("post_rst_valid", {31'd0, out_valid0}, 32'd1);
    chk("post_rst_sum", {16'd0, out_sum0}, 32'h0009);
    chk("post_rst_ovf", {31'd0, out_ovf0}, 32'd0);
    handshake();

    // Maximum burst length 255, adding 1 each beat.
    kick(8'd255);
    in_valid = 1'b1; in_sub = 1'b0; in_data = 16'h0001;
    for (int i = 0; i < 254; i++) step();
    chk("max_no_early_valid", {31'd0, out_valid0}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("max_valid", {31'd0, out_valid0}, 32'd1);
    chk("max_sum", {16'd0, out_sum0}, 32'h00FF);
    chk("max_ovf", {31'd0, out_ovf0}, 32'd0);
    handshake();
    chk("max_idle", st0(), {12'd0, 4'b0000, 16'h00FF});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
